// File: rtl/ddr_port_arbiter_if.sv
// rtl/ddr_port_arbiter_if.sv - requester and DDR3 app-side signal bundle for ddr_port_arbiter
// slave is the arbiter's view; master is the view of the requesters plus memory controller.
interface ddr_port_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int LEN_W  = 5
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]  rd_len;
  logic              rd_ack;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_done;

  logic [ADDR_W-1:0] app_addr;
  logic [2:0]        app_cmd;
  logic              app_en;
  logic              app_rdy;
  logic [DATA_W-1:0] app_wdf_data;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic              app_wdf_rdy;
  logic [DATA_W-1:0] app_rd_data;
  logic              app_rd_data_valid;

  modport slave (
    input  wr_req, wr_addr, wr_data,
    output wr_ack,
    input  rd_req, rd_addr, rd_len,
    output rd_ack, rd_data, rd_valid, rd_done,
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );

  modport master (
    output wr_req, wr_addr, wr_data,
    input  wr_ack,
    output rd_req, rd_addr, rd_len,
    input  rd_ack, rd_data, rd_valid, rd_done,
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
  );
endinterface

// File: rtl/ddr_port_arbiter.sv
// rtl/ddr_port_arbiter.sv - two-port arbiter onto the DDR3 controller app interface
// Display bursts have priority; a starve counter guarantees the single-beat write port a slot.
module ddr_port_arbiter #(
  parameter int ADDR_W       = 28,
  parameter int DATA_W       = 128,
  parameter int LEN_W        = 5,
  parameter int ADDR_STEP    = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                sys_rst,
  input  logic                calib_done,
  output logic                busy,
  ddr_port_arbiter_if.slave   bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int OW = LEN_W + 1;

  typedef enum logic [1:0] {IDLE, WR, RD_ISSUE, RD_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
  logic [LEN_W-1:0]  issue_left_q, issue_left_d;
  logic [OW-1:0]     outstanding_q, outstanding_d;
  logic [ADDR_W-1:0] app_addr_q, app_addr_d;
  logic [2:0]        app_cmd_q, app_cmd_d;
  logic              app_en_q, app_en_d;
  logic [DATA_W-1:0] app_wdf_data_q, app_wdf_data_d;
  logic              app_wdf_wren_q, app_wdf_wren_d;
  logic              wr_ack_q, wr_ack_d;
  logic              rd_ack_q, rd_ack_d;
  logic              rd_done_q, rd_done_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic arb_ok, grant_wr, grant_rd, starve_full, cmd_fire, beat_fire, burst_active;

  // While an ack is visible the requester is still withdrawing its request, so hold off arbitration.
  always_comb begin
    starve_full  = (starve_cnt_q == SW'(STARVE_LIMIT));
    arb_ok       = (state_q == IDLE) && calib_done && !wr_ack_q && !rd_ack_q;
    grant_wr     = arb_ok && bus.wr_req && (!bus.rd_req || starve_full);
    grant_rd     = arb_ok && bus.rd_req && !grant_wr;
    burst_active = (state_q == RD_ISSUE) || (state_q == RD_DRAIN);
    cmd_fire     = (state_q == RD_ISSUE) && app_en_q && bus.app_rdy;
    beat_fire    = burst_active && bus.app_rd_data_valid && (outstanding_q != '0);
  end

  always_comb begin
    state_d        = state_q;
    starve_cnt_d   = starve_cnt_q;
    issue_left_d   = issue_left_q;
    outstanding_d  = outstanding_q;
    app_addr_d     = app_addr_q;
    app_cmd_d      = app_cmd_q;
    app_en_d       = app_en_q;
    app_wdf_data_d = app_wdf_data_q;
    app_wdf_wren_d = app_wdf_wren_q;
    wr_ack_d       = 1'b0;
    rd_ack_d       = 1'b0;
    rd_done_d      = 1'b0;
    rd_valid_d     = beat_fire;
    rd_data_d      = beat_fire ? bus.app_rd_data : rd_data_q;

    if (!bus.wr_req || grant_wr) begin
      starve_cnt_d = '0;
    end else if (grant_rd) begin
      starve_cnt_d = starve_cnt_q + SW'(1);
    end

    case ({cmd_fire, beat_fire})
      2'b10:   outstanding_d = outstanding_q + OW'(1);
      2'b01:   outstanding_d = outstanding_q - OW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    case (state_q)
      IDLE: begin
        if (grant_wr) begin
          state_d        = WR;
          app_en_d       = 1'b1;
          app_wdf_wren_d = 1'b1;
          app_cmd_d      = 3'b000;
          app_addr_d     = bus.wr_addr;
          app_wdf_data_d = bus.wr_data;
        end else if (grant_rd) begin
          rd_ack_d = 1'b1;
          if (bus.rd_len == '0) begin
            rd_done_d = 1'b1;
          end else begin
            state_d      = RD_ISSUE;
            app_en_d     = 1'b1;
            app_cmd_d    = 3'b001;
            app_addr_d   = bus.rd_addr;
            issue_left_d = bus.rd_len;
          end
        end
      end
      WR: begin
        // Command and data channels retire independently; ack once both have been taken.
        app_en_d       = app_en_q && !bus.app_rdy;
        app_wdf_wren_d = app_wdf_wren_q && !bus.app_wdf_rdy;
        if (!app_en_d && !app_wdf_wren_d) begin
          wr_ack_d = 1'b1;
          state_d  = IDLE;
        end
      end
      RD_ISSUE: begin
        if (cmd_fire) begin
          app_addr_d   = app_addr_q + ADDR_W'(ADDR_STEP);
          issue_left_d = issue_left_q - LEN_W'(1);
          if (issue_left_q == LEN_W'(1)) begin
            app_en_d = 1'b0;
            state_d  = RD_DRAIN;
          end
        end
      end
      RD_DRAIN: begin
        if (beat_fire && (outstanding_q == OW'(1))) begin
          rd_done_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q        <= IDLE;
      starve_cnt_q   <= '0;
      issue_left_q   <= '0;
      outstanding_q  <= '0;
      app_addr_q     <= '0;
      app_cmd_q      <= '0;
      app_en_q       <= 1'b0;
      app_wdf_data_q <= '0;
      app_wdf_wren_q <= 1'b0;
      wr_ack_q       <= 1'b0;
      rd_ack_q       <= 1'b0;
      rd_done_q      <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      starve_cnt_q   <= starve_cnt_d;
      issue_left_q   <= issue_left_d;
      outstanding_q  <= outstanding_d;
      app_addr_q     <= app_addr_d;
      app_cmd_q      <= app_cmd_d;
      app_en_q       <= app_en_d;
      app_wdf_data_q <= app_wdf_data_d;
      app_wdf_wren_q <= app_wdf_wren_d;
      wr_ack_q       <= wr_ack_d;
      rd_ack_q       <= rd_ack_d;
      rd_done_q      <= rd_done_d;
      rd_valid_q     <= rd_valid_d;
      rd_data_q      <= rd_data_d;
    end
  end

  assign bus.wr_ack       = wr_ack_q;
  assign bus.rd_ack       = rd_ack_q;
  assign bus.rd_done      = rd_done_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.app_addr     = app_addr_q;
  assign bus.app_cmd      = app_cmd_q;
  assign bus.app_en       = app_en_q;
  assign bus.app_wdf_data = app_wdf_data_q;
  assign bus.app_wdf_wren = app_wdf_wren_q;
  assign bus.app_wdf_end  = 1'b1;
  assign busy             = (state_q != IDLE);
endmodule

// File: tb/tb_ddr_port_arbiter.sv
// tb/tb_ddr_port_arbiter.sv - randomized directed bench for ddr_port_arbiter
// A transaction-level controller model logs commands and returns data; expectations come from address arithmetic.
module tb_ddr_port_arbiter;
  localparam int AW    = 28;
  localparam int DW    = 128;
  localparam int LW    = 5;
  localparam int STEP  = 8;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic sys_rst;
  logic calib_done;
  logic busy;

  always #5 clk = ~clk;

  ddr_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

  ddr_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .ADDR_STEP(STEP), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .sys_rst(sys_rst), .calib_done(calib_done), .busy(busy), .bus(bus)
  );

  typedef struct { int cyc; logic [AW-1:0] addr; logic [2:0] cmd; } cmd_t;
  typedef struct { int cyc; logic [DW-1:0] data; } wdf_t;
  typedef struct { int due; logic [DW-1:0] data; } ret_t;
  typedef struct { logic [DW-1:0] data; logic done; } beat_t;

  cmd_t  cmd_log[$];
  wdf_t  wdf_log[$];
  ret_t  ret_q[$];
  beat_t beat_log[$];
  int    grants[$];

  int checks = 0, errors = 0, cyc = 0;
  int rdy_mode = 0, wdf_mode = 0, stall = 0, lat = 10;
  int en_cycles = 0, first_en_cyc = 0, wr_ack_cnt = 0, wr_ack_cyc = -1;
  int rd_ack_cyc = -1, rd_done_cyc = -1;
  logic [31:0] salt = 32'h1234_5678;
  logic rdy = 1'b0, wrdy = 1'b0, en_prev = 1'b0;

  function automatic logic [DW-1:0] pat(logic [AW-1:0] a, logic [31:0] s);
    return {4'h0, a, ~s, s ^ {4'h0, a}, s};
  endfunction

  task automatic check(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic check_data(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    cmd_log.delete(); wdf_log.delete(); beat_log.delete(); grants.delete();
    en_cycles = 0; wr_ack_cnt = 0; wr_ack_cyc = -1; rd_ack_cyc = -1; rd_done_cyc = -1;
  endtask

  // Memory controller model plus output monitor, stepping once per falling edge.
  initial begin
    bus.app_rdy = 1'b0; bus.app_wdf_rdy = 1'b0;
    bus.app_rd_data = '0; bus.app_rd_data_valid = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = ~rdy;
        2:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (stall == 0);
      endcase
      if (rdy_mode == 3 && bus.app_en && stall > 0) stall--;
      wrdy = (wdf_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.app_rdy = rdy;
      bus.app_wdf_rdy = wrdy;
      if (bus.app_en) begin
        en_cycles++;
        if (!en_prev) first_en_cyc = cyc;
      end
      en_prev = bus.app_en;
      if (bus.app_en && rdy) begin
        cmd_log.push_back('{cyc, bus.app_addr, bus.app_cmd});
        if (bus.app_cmd == 3'b001) ret_q.push_back('{cyc + lat, pat(bus.app_addr, salt)});
      end
      if (bus.app_wdf_wren && wrdy) wdf_log.push_back('{cyc, bus.app_wdf_data});
      if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
        bus.app_rd_data = ret_q[0].data;
        bus.app_rd_data_valid = 1'b1;
        void'(ret_q.pop_front());
      end else begin
        bus.app_rd_data_valid = 1'b0;
      end
      if (bus.rd_valid) beat_log.push_back('{bus.rd_data, bus.rd_done});
      if (bus.rd_ack) begin grants.push_back(0); rd_ack_cyc = cyc; end
      if (bus.wr_ack) begin grants.push_back(1); wr_ack_cnt++; wr_ack_cyc = cyc; end
      if (bus.rd_done) rd_done_cyc = cyc;
    end
  end

  task automatic do_write(logic [AW-1:0] a, logic [DW-1:0] d, output bit ok);
    @(negedge clk);
    bus.wr_req = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (bus.wr_ack) ok = 1'b1;
    end
    bus.wr_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_read(logic [AW-1:0] a, int len, output bit ok);
    bit acked, done;
    @(negedge clk);
    bus.rd_req = 1'b1; bus.rd_addr = a; bus.rd_len = LW'(len);
    acked = 1'b0; done = 1'b0;
    for (int i = 0; i < 300 && !acked; i++) begin
      @(negedge clk);
      if (bus.rd_ack) acked = 1'b1;
      if (bus.rd_done) done = 1'b1;
    end
    bus.rd_req = 1'b0;
    for (int i = 0; i < 800 && acked && !done; i++) begin
      @(negedge clk);
      if (bus.rd_done) done = 1'b1;
    end
    ok = acked && done;
    @(negedge clk);
  endtask

  task automatic check_read(string tag, logic [AW-1:0] a, int len, bit no_gap);
    logic [AW-1:0] ea;
    check({tag, "_ncmd"}, cmd_log.size(), len);
    check({tag, "_nbeat"}, beat_log.size(), len);
    for (int k = 0; k < len && k < cmd_log.size(); k++) begin
      ea = a + AW'(k * STEP);
      check({tag, "_addr"}, int'(cmd_log[k].addr), int'(ea));
      check({tag, "_cmd"}, int'(cmd_log[k].cmd), 1);
      if (no_gap && k > 0) check({tag, "_gap"}, cmd_log[k].cyc - cmd_log[k-1].cyc, 1);
    end
    for (int k = 0; k < len && k < beat_log.size(); k++) begin
      ea = a + AW'(k * STEP);
      check_data({tag, "_data"}, beat_log[k].data, pat(ea, salt));
      check({tag, "_done"}, int'(beat_log[k].done), (k == len - 1) ? 1 : 0);
    end
  endtask

  initial begin
    logic [AW-1:0] a, wa;
    logic [DW-1:0] d;
    int len, b0, nrd, nwr;
    bit ok, is_wr;

    sys_rst = 1'b1; calib_done = 1'b0;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_req = 1'b0; bus.rd_addr = '0; bus.rd_len = '0;
    #2 sys_rst = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_app_en", int'(bus.app_en), 0);
    check("rst_wdf_wren", int'(bus.app_wdf_wren), 0);
    check("rst_wdf_end", int'(bus.app_wdf_end), 1);
    check("rst_app_cmd", int'(bus.app_cmd), 0);
    check("rst_app_addr", int'(bus.app_addr), 0);
    check("rst_wr_ack", int'(bus.wr_ack), 0);
    check("rst_rd_ack", int'(bus.rd_ack), 0);
    check("rst_rd_valid", int'(bus.rd_valid), 0);
    check("rst_rd_done", int'(bus.rd_done), 0);
    check_data("rst_rd_data", bus.rd_data, '0);
    check("rst_busy", int'(busy), 0);

    sys_rst = 1'b1; calib_done = 1'b1;
    repeat (2) @(negedge clk);

    // Single write with the command channel stalled three cycles.
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    rdy_mode = 3; stall = 3; wdf_mode = 0;
    clear_logs();
    do_write(AW'(28'h40), d, ok);
    check("wr_timeout", int'(ok), 1);
    check("wr_ncmd", cmd_log.size(), 1);
    check("wr_nwdf", wdf_log.size(), 1);
    if (cmd_log.size() == 1) begin
      check("wr_addr", int'(cmd_log[0].addr), 'h40);
      check("wr_cmd", int'(cmd_log[0].cmd), 0);
      check("wr_cmd_cycle", cmd_log[0].cyc - first_en_cyc + 1, 4);
    end
    if (wdf_log.size() == 1) begin
      check_data("wr_data", wdf_log[0].data, d);
      check("wr_wdf_cycle", wdf_log[0].cyc - first_en_cyc + 1, 1);
    end
    check("wr_ack_count", wr_ack_cnt, 1);
    check("wr_ack_after_both", int'(wr_ack_cyc > cmd_log[0].cyc), 1);
    check("wr_busy_after", int'(busy), 0);

    // Five-beat burst at 0x100 with ten-cycle return latency.
    rdy_mode = 0; lat = 10; salt = $urandom();
    clear_logs();
    do_read(AW'(28'h100), 5, ok);
    check("rd5_timeout", int'(ok), 1);
    check_read("rd5", AW'(28'h100), 5, 1'b1);

    // Starvation: both requests held; four bursts go first, then the write.
    lat = $urandom_range(2, 12); len = $urandom_range(1, 4); salt = $urandom();
    a = AW'($urandom()) & ~AW'(7);
    wa = AW'($urandom()) & ~AW'(7);
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    clear_logs();
    @(negedge clk);
    bus.rd_req = 1'b1; bus.rd_addr = a; bus.rd_len = LW'(len);
    bus.wr_req = 1'b1; bus.wr_addr = wa; bus.wr_data = d;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (bus.wr_ack) ok = 1'b1;
    end
    bus.rd_req = 1'b0; bus.wr_req = 1'b0;
    repeat (3) @(negedge clk);
    check("starve_timeout", int'(ok), 1);
    check("starve_ngrants", grants.size(), LIMIT + 1);
    for (int k = 0; k < grants.size() && k <= LIMIT; k++)
      check("starve_order", grants[k], (k == LIMIT) ? 1 : 0);
    nrd = 0; nwr = 0;
    foreach (cmd_log[k]) begin
      if (cmd_log[k].cmd == 3'b001) nrd++;
      else if (cmd_log[k].addr == wa) nwr++;
    end
    check("starve_nrd_cmds", nrd, LIMIT * len);
    check("starve_nwr_cmds", nwr, 1);
    check("starve_nbeats", beat_log.size(), LIMIT * len);
    for (int k = 0; k < beat_log.size(); k++)
      check_data("starve_beat", beat_log[k].data, pat(a + AW'((k % len) * STEP), salt));
    if (wdf_log.size() > 0) check_data("starve_wdata", wdf_log[0].data, d);
    check("starve_cnt_clear", int'(dut.starve_cnt_q), 0);

    // Ten-beat burst with app_rdy toggling; data returns while issuing.
    rdy_mode = 1; lat = 3; salt = $urandom();
    a = AW'($urandom()) & ~AW'(7);
    clear_logs();
    do_read(a, 10, ok);
    check("bp_timeout", int'(ok), 1);
    check_read("bp", a, 10, 1'b0);
    check("bp_overlap", int'(beat_log.size() > 0 && cmd_log.size() == 10), 1);
    check("bp_outstanding", int'(dut.outstanding_q), 0);
    check("bp_busy", int'(busy), 0);

    // Zero-length burst completes without touching the controller.
    rdy_mode = 0;
    clear_logs();
    do_read(AW'($urandom()) & ~AW'(7), 0, ok);
    check("len0_timeout", int'(ok), 1);
    check("len0_same_cycle", rd_done_cyc, rd_ack_cyc);
    check("len0_no_app_en", en_cycles, 0);
    check("len0_nbeats", beat_log.size(), 0);

    // Calibration gate holds both requests, then read wins, then write.
    calib_done = 1'b0; lat = 4; salt = $urandom();
    a = AW'($urandom()) & ~AW'(7);
    clear_logs();
    @(negedge clk);
    bus.rd_req = 1'b1; bus.rd_addr = a; bus.rd_len = LW'(2);
    bus.wr_req = 1'b1; bus.wr_addr = a ^ AW'(28'h80); bus.wr_data = d;
    repeat (20) @(negedge clk);
    check("calib_no_grant", grants.size(), 0);
    check("calib_not_busy", int'(busy), 0);
    calib_done = 1'b1;
    for (int i = 0; i < 400 && (bus.rd_req || bus.wr_req); i++) begin
      @(negedge clk);
      if (bus.rd_ack) bus.rd_req = 1'b0;
      if (bus.wr_ack) bus.wr_req = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("calib_timeout", int'(bus.rd_req || bus.wr_req), 0);
    check("calib_ngrants", grants.size(), 2);
    if (grants.size() == 2) begin
      check("calib_first_rd", grants[0], 0);
      check("calib_then_wr", grants[1], 1);
    end
    check("calib_nbeats", beat_log.size(), 2);

    // Random mix under random backpressure, including an address wrap.
    rdy_mode = 2; wdf_mode = 1;
    for (int n = 0; n < 8; n++) begin
      lat = $urandom_range(1, 15); salt = $urandom();
      is_wr = (n != 3) && ($urandom_range(0, 2) == 0);
      a = (n == 3) ? ~AW'(15) : (AW'($urandom()) & ~AW'(7));
      len = (n == 3) ? 4 : $urandom_range(1, 31);
      clear_logs();
      if (is_wr) begin
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        do_write(a, d, ok);
        check("rnd_wr_timeout", int'(ok), 1);
        check("rnd_wr_ncmd", cmd_log.size(), 1);
        if (cmd_log.size() == 1) check("rnd_wr_addr", int'(cmd_log[0].addr), int'(a));
        if (wdf_log.size() == 1) check_data("rnd_wr_data", wdf_log[0].data, d);
        check("rnd_wr_ack", wr_ack_cnt, 1);
      end else begin
        do_read(a, len, ok);
        check("rnd_rd_timeout", int'(ok), 1);
        check_read("rnd_rd", a, len, 1'b0);
      end
    end

    // Reset in the middle of issuing a ten-beat burst.
    rdy_mode = 0; wdf_mode = 0; lat = 10; salt = $urandom();
    a = AW'($urandom()) & ~AW'(7);
    clear_logs();
    @(negedge clk);
    bus.rd_req = 1'b1; bus.rd_addr = a; bus.rd_len = LW'(10);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.rd_ack) bus.rd_req = 1'b0;
      if (cmd_log.size() >= 4) ok = 1'b1;
    end
    bus.rd_req = 1'b0;
    check("mid_rst_reached_issue", int'(ok && busy), 1);
    b0 = beat_log.size();
    #2 sys_rst = 1'b0;
    #1;
    check("mid_rst_app_en", int'(bus.app_en), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_rd_valid", int'(bus.rd_valid), 0);
    check("mid_rst_app_addr", int'(bus.app_addr), 0);
    @(negedge clk);
    sys_rst = 1'b1;
    repeat (25) @(negedge clk);
    check("mid_rst_late_beats", beat_log.size(), b0);
    check("mid_rst_outstanding", int'(dut.outstanding_q), 0);
    check("mid_rst_ret_drained", ret_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ddr_port_arbiter.md
Name: ddr_port_arbiter

Overview:
- Shares the single DDR3 controller user (app_*) interface between two requesters.
  - Write port: the fractal renderer, single 128-bit beat writes.
  - Read port: the VGA line fetcher, bursts of consecutive 128-bit beats.
- Sits between both requesters and the memory controller, in the controller's user clock domain.
- Display reads have priority. Writes are protected from starvation by a bounded grant counter.

Parameters:
- ADDR_W, 28, app address width.
- DATA_W, 128, beat width.
- LEN_W, 5, width of read burst length (max 2^LEN_W-1 beats).
- ADDR_STEP, 8, address increment per beat.
- STARVE_LIMIT, 4, consecutive read bursts allowed while a write is pending.

Ports:
- clk in 1: controller user clock.
- sys_rst in 1: async active-low reset.
- calib_done in 1: controller calibration complete.
- wr_req in 1: write request, held until wr_ack.
- wr_addr in ADDR_W: write address (multiple of ADDR_STEP).
- wr_data in DATA_W: write beat.
- wr_ack out 1: one-cycle pulse, write command and data both accepted.
- rd_req in 1: burst read request, held until rd_ack.
- rd_addr in ADDR_W: burst start address.
- rd_len in LEN_W: beat count, 0 = no-op.
- rd_ack out 1: one-cycle pulse when burst is latched.
- rd_data out DATA_W: returned beat.
- rd_valid out 1: rd_data qualifier.
- rd_done out 1: one-cycle pulse with the last beat of a burst.
- app_addr out ADDR_W: controller command address.
- app_cmd out 3: controller command (000 write, 001 read).
- app_en out 1: controller command valid.
- app_rdy in 1: controller command ready.
- app_wdf_data out DATA_W: controller write data.
- app_wdf_wren out 1: controller write data valid.
- app_wdf_end out 1: controller write data end.
- app_wdf_rdy in 1: controller write data ready.
- app_rd_data in DATA_W: controller read data.
- app_rd_data_valid in 1: controller read data valid.
- busy out 1: state != IDLE.

Behaviour:
- **Reset** (sys_rst low, async):
  - state=IDLE.
  - All outputs 0, except app_wdf_end, which is tied 1.
  - Beat counters, outstanding counter and starve counter 0.
- **Calibration gate:** no grant while calib_done=0. Requests stay pending.
- **States:** IDLE, WR, RD_ISSUE, RD_DRAIN.
- **IDLE arbitration, evaluated each cycle:**
  - Write wins if wr_req and (rd_req=0 or starve_cnt==STARVE_LIMIT).
  - Otherwise read wins if rd_req.
  - Both requests in the same cycle with starve_cnt<STARVE_LIMIT: read wins, starve_cnt increments.
  - starve_cnt clears on every write grant, and whenever wr_req=0.
- **Read grant:**
  - rd_ack pulses; rd_addr and rd_len are latched.
  - rd_len=0: rd_ack and rd_done pulse together, stay in IDLE.
  - Otherwise go to RD_ISSUE.
- **WR:**
  - Entry cycle drives app_en=1, app_wdf_wren=1, app_cmd=000, app_addr=wr_addr, app_wdf_data=wr_data.
  - app_en drops in the cycle after a cycle with app_en&app_rdy.
  - app_wdf_wren drops in the cycle after a cycle with app_wdf_wren&app_wdf_rdy. The two handshakes complete independently.
  - When both are low: wr_ack pulses, return to IDLE.
  - Command and data registers are held stable until their respective acceptance.
- **RD_ISSUE:**
  - Issues read commands (app_cmd=001) at latched address + k*ADDR_STEP, k=0..len-1.
  - A command counts as issued on each cycle with app_en&app_rdy. Address advances on that cycle. No gaps required when app_rdy stays high.
  - After the last command issues, go to RD_DRAIN.
- **Outstanding counter:**
  - +1 per issued command, -1 per app_rd_data_valid. Simultaneous events net 0.
- **Read data forwarding:**
  - rd_data/rd_valid are registered copies of app_rd_data/app_rd_data_valid: 1-cycle latency, in order.
  - Data may arrive while still in RD_ISSUE and is forwarded there.
- **RD_DRAIN:**
  - Waits until all beats have returned.
  - rd_done pulses coincident with rd_valid of the final beat, then return to IDLE.
- **Ignored signals:**
  - app_rd_data_valid outside an active burst is ignored.
  - New wr_req/rd_req during a transaction is not sampled until IDLE.
- **Address:** wraps modulo 2^ADDR_W.
- **Reset mid-operation:** abandons the transaction. Beats returning after reset release are ignored.

Test Plan:
- **Single write:** calib_done=1, wr_req, wr_addr=0x40, app_rdy low 3 cycles, app_wdf_rdy high.
  - Required: wdf accepted cycle 1, command accepted cycle 4.
  - Required: wr_ack pulses once after both handshakes, app_addr=0x40.
- **Read burst:** rd_addr=0x100, rd_len=5, controller returns data with 10-cycle latency.
  - Required: commands at 0x100,0x108,...,0x120.
  - Required: 5 rd_valid beats in order; rd_done on the 5th.
- **Starvation:** rd_req held continuously, wr_req held, STARVE_LIMIT=4.
  - Required: exactly 4 bursts granted, then the write; starve_cnt resets.
- **Backpressure and overlap:** app_rdy toggles every cycle during a rd_len=10 burst, with data returning mid-issue.
  - Required: 10 commands, 10 beats; outstanding counter back to 0; rd_done once.
- **Edge cases:**
  - rd_len=0 -> rd_ack and rd_done in the same cycle, no app_en.
  - calib_done=0 with requests pending -> no grant until calib_done rises.
- **Async reset mid-burst:** sys_rst low during RD_ISSUE of a 10-beat burst.
  - Required: outputs 0 immediately, state=IDLE.
  - Required: late app_rd_data_valid produces no rd_valid.
